// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: sits between the IF stage and ID.
// It pairs each accepted fetch PC with the SRAM data that returns one cycle
// later, selects the 32-bit instruction word, and buffers {pc, inst} so a
// stalled ID never loses fetched instructions. A taken branch flushes
// everything, and a stall request is raised when another fetch might not fit.
module if_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [64:0] br_bus,
    input  logic        req_valid,
    input  logic [63:0] req_pc,
    input  logic [63:0] inst_sram_rdata,
    output logic [96:0] if_to_id_bus,
    output logic        stallreq_fq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   FILL_FULL = (CNT_W + 1)'(DEPTH);

    // Decoded controls
    logic             br_e_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             valid_s;
    logic [31:0]      inst_sel_s;
    logic [CNT_W:0]   fill_s;
    logic             unused_s;

    // Pending-fetch and FIFO state
    logic             p_valid_q, p_valid_d;
    logic [63:0]      p_pc_q,    p_pc_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [63:0]      fifo_pc_q   [DEPTH];
    logic [63:0]      fifo_pc_d   [DEPTH];
    logic [31:0]      fifo_inst_q [DEPTH];
    logic [31:0]      fifo_inst_d [DEPTH];

    // Only the IF and ID stall bits and the branch-enable bit matter here.
    assign unused_s = ^{stall[5:2], br_bus[63:0]};

    // Decode accept / push / pop conditions and select the instruction half-word.
    always_comb begin
        br_e_s   = br_bus[64];
        accept_s = req_valid && !stall[0] && !br_e_s;
        push_s   = p_valid_q && !br_e_s;
        valid_s  = (count_q != CNT_ZERO) && !br_e_s;
        pop_s    = valid_s && !stall[1];
        if (p_pc_q[2]) begin
            inst_sel_s = inst_sram_rdata[63:32];
        end else begin
            inst_sel_s = inst_sram_rdata[31:0];
        end
        // Occupancy including the fetch whose data has not yet returned.
        fill_s = {1'b0, count_q} + {{CNT_W{1'b0}}, p_valid_q};
    end

    // Drive the ID bus and the full request from registered state.
    always_comb begin
        stallreq_fq = (fill_s >= FILL_FULL);
        if (valid_s) begin
            if_to_id_bus = {1'b1, fifo_pc_q[rd_ptr_q], fifo_inst_q[rd_ptr_q]};
        end else begin
            if_to_id_bus = 97'd0;
        end
    end

    // Compute next pending-fetch, pointer, count and entry state.
    always_comb begin
        p_valid_d   = p_valid_q;
        p_pc_d      = p_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        if (br_e_s) begin
            // Flush: drop the in-flight fetch and empty the queue; the SRAM
            // data returning this cycle belongs to the wrong path.
            p_valid_d = 1'b0;
            rd_ptr_d  = PTR_ZERO;
            wr_ptr_d  = PTR_ZERO;
            count_d   = CNT_ZERO;
        end else begin
            p_valid_d = accept_s;
            if (accept_s) begin
                p_pc_d = req_pc;
            end else begin
                p_pc_d = p_pc_q;
            end
            if (push_s) begin
                fifo_pc_d[wr_ptr_q]   = p_pc_q;
                fifo_inst_d[wr_ptr_q] = inst_sel_s;
                wr_ptr_d              = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q <= 1'b0;
            p_pc_q    <= 64'd0;
            rd_ptr_q  <= PTR_ZERO;
            wr_ptr_q  <= PTR_ZERO;
            count_q   <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= 64'd0;
                fifo_inst_q[i] <= 32'd0;
            end
        end else begin
            p_valid_q <= p_valid_d;
            p_pc_q    <= p_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= fifo_pc_d[i];
                fifo_inst_q[i] <= fifo_inst_d[i];
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: a reference queue is filled when
// fetch data returns and drained when ID takes an entry; scenario tasks add
// their own targeted checks.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tb_stall0, tb_stall1;
    logic [5:0]  stall;
    logic        br_e;
    logic [63:0] br_addr;
    logic [64:0] br_bus;
    logic        req_valid;
    logic [63:0] req_pc;
    logic [63:0] rdata;
    logic [96:0] bus;
    logic        stallreq_fq;
    bit          rand_rd;

    int vectors     = 0;
    int miscompares = 0;
    bit sb_en       = 1'b0;

    // Reference model state
    logic [95:0] exp_q [$];
    bit          m_pv  = 1'b0;
    logic [63:0] m_ppc = 64'd0;

    // CTRL feeds the queue-full request back into the IF stall bit.
    assign stall  = {4'b0000, tb_stall1, tb_stall0 | stallreq_fq};
    assign br_bus = {br_e, br_addr};

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_bus         (br_bus),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .inst_sram_rdata(rdata),
        .if_to_id_bus   (bus),
        .stallreq_fq    (stallreq_fq)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare outputs mid-cycle, then advance the model to the next edge.
    always @(negedge clk) begin
        if (sb_en) begin
            logic        exp_v;
            logic [96:0] exp_bus;
            logic        exp_full;
            exp_v    = (exp_q.size() != 0) && !br_e;
            exp_bus  = exp_v ? {1'b1, exp_q[0]} : 97'd0;
            exp_full = ((exp_q.size() + int'(m_pv)) >= DEPTH);
            vectors++;
            if (bus !== exp_bus) begin
                miscompares++;
                $display("FAIL sb_bus t=%0t got %h expected %h", $time, bus, exp_bus);
            end
            vectors++;
            if (stallreq_fq !== exp_full) begin
                miscompares++;
                $display("FAIL sb_stallreq t=%0t got %b expected %b", $time, stallreq_fq, exp_full);
            end
            vectors++;
            if (dut.count_q > DEPTH) begin
                miscompares++;
                $display("FAIL count_range t=%0t got %0d expected <= %0d", $time, dut.count_q, DEPTH);
            end
            if (rst) begin
                exp_q.delete();
                m_pv  = 1'b0;
                m_ppc = 64'd0;
            end else if (br_e) begin
                exp_q.delete();
                m_pv = 1'b0;
            end else begin
                if (exp_v && !stall[1]) void'(exp_q.pop_front());
                if (m_pv) exp_q.push_back({m_ppc, m_ppc[2] ? rdata[63:32] : rdata[31:0]});
                m_pv = req_valid && !stall[0];
                if (m_pv) m_ppc = req_pc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rd) rdata = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        tb_stall1 = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_pc = 64'h1000;
        tick();
        sb_en = 1'b1;
        tick();
        vectors++;
        if (bus !== 97'd0) begin
            miscompares++; $display("FAIL reset_bus got %h expected 0", bus);
        end
        vectors++;
        if (stallreq_fq !== 1'b0) begin
            miscompares++; $display("FAIL reset_stallreq got %b expected 0", stallreq_fq);
        end
        rst = 1'b0; req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (bus[96] !== 1'b0) begin
                miscompares++; $display("FAIL post_reset_idle got valid=%b expected 0", bus[96]);
            end
        end
    endtask

    task automatic test_streaming();
        logic [96:0] exp;
        rand_rd = 1'b0; rdata = 64'h1111_2222_3333_4444; tb_stall1 = 1'b0;
        req_valid = 1'b1; req_pc = 64'h8000_0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            case (k)
                2:       exp = {1'b1, 64'h8000_0000, 32'h3333_4444};
                3:       exp = {1'b1, 64'h8000_0004, 32'h1111_2222};
                4:       exp = {1'b1, 64'h8000_0008, 32'h3333_4444};
                default: exp = 97'd0;
            endcase
            vectors++;
            if (bus !== exp) begin
                miscompares++; $display("FAIL stream_k%0d got %h expected %h", k, bus, exp);
            end
            if (k == 1) req_pc = 64'h8000_0004;
            else if (k == 2) req_pc = 64'h8000_0008;
            else req_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] base;
        int          accepted;
        int          n;
        bit          acc;
        base = 64'h8000_1000; accepted = 0; n = 0;
        rand_rd = 1'b1; tb_stall1 = 1'b1; req_valid = 1'b1; req_pc = base;
        for (int k = 0; k < 8; k++) begin
            acc = req_valid && !stall[0];
            tick();
            if (acc) begin accepted++; req_pc = req_pc + 64'd4; end
        end
        vectors++;
        if (accepted !== 4) begin
            miscompares++; $display("FAIL bp_accepted got %0d expected 4", accepted);
        end
        vectors++;
        if (dut.count_q !== 3'd4) begin
            miscompares++; $display("FAIL bp_count got %0d expected 4", dut.count_q);
        end
        vectors++;
        if (stallreq_fq !== 1'b1) begin
            miscompares++; $display("FAIL bp_stallreq got %b expected 1", stallreq_fq);
        end
        vectors++;
        if (bus[96:32] !== {1'b1, base}) begin
            miscompares++; $display("FAIL bp_head got %h expected %h", bus[96:32], {1'b1, base});
        end
        tb_stall1 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k == 6) req_valid = 1'b0;
            if (bus[96]) begin
                vectors++;
                if (bus[95:32] !== base + 64'(4 * n)) begin
                    miscompares++;
                    $display("FAIL bp_drain_pc got %h expected %h", bus[95:32], base + 64'(4 * n));
                end
                n++;
            end
            acc = req_valid && !stall[0];
            tick();
            if (acc) begin accepted++; req_pc = req_pc + 64'd4; end
        end
        vectors++;
        if (n !== accepted) begin
            miscompares++; $display("FAIL bp_drain_count got %0d expected %0d", n, accepted);
        end
    endtask

    task automatic test_if_stall();
        int seen;
        seen = 0;
        tb_stall0 = 1'b1; req_valid = 1'b1; req_pc = 64'h8000_0010;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (bus[96] !== 1'b0) begin
                miscompares++; $display("FAIL ifstall_hold got valid=%b expected 0", bus[96]);
            end
        end
        tb_stall0 = 1'b0;
        tick();
        req_valid = 1'b0; req_pc = 64'h8000_0ff0;
        for (int k = 0; k < 6; k++) begin
            if (bus[96]) begin
                seen++;
                vectors++;
                if (bus[95:32] !== 64'h8000_0010) begin
                    miscompares++; $display("FAIL ifstall_pc got %h expected 8000000000000010", bus[95:32]);
                end
            end
            tick();
        end
        vectors++;
        if (seen !== 1) begin
            miscompares++; $display("FAIL ifstall_count got %0d expected 1", seen);
        end
    endtask

    task automatic test_flush();
        br_addr = 64'h8000_0100;
        tb_stall1 = 1'b1; req_valid = 1'b1; req_pc = 64'h8000_0200;
        for (int k = 0; k < 4; k++) begin
            tick();
            req_pc = req_pc + 64'd4;
        end
        vectors++;
        if (dut.count_q !== 3'd3 || dut.p_valid_q !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_setup got count=%0d pv=%b expected 3/1", dut.count_q, dut.p_valid_q);
        end
        br_e = 1'b1; req_valid = 1'b1; req_pc = 64'h8000_0100; tb_stall1 = 1'b0;
        #1;
        vectors++;
        if (bus !== 97'd0) begin
            miscompares++; $display("FAIL flush_cycle_bus got %h expected 0", bus);
        end
        tick();
        br_e = 1'b0;
        vectors++;
        if (dut.count_q !== 3'd0 || dut.p_valid_q !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_after got count=%0d pv=%b expected 0/0", dut.count_q, dut.p_valid_q);
        end
        tick();
        req_valid = 1'b0;
        tick();
        vectors++;
        if (bus[96:32] !== {1'b1, 64'h8000_0100}) begin
            miscompares++; $display("FAIL flush_target got %h expected 18000000000000100", bus[96:32]);
        end
    endtask

    task automatic test_wrap();
        int  hits;
        bit  pre;
        bit  acc;
        hits = 0;
        // A one-cycle flush puts both pointers at 0 so the steady push/pop lands on slot 3.
        br_e = 1'b1; req_valid = 1'b0;
        tick();
        br_e = 1'b0;
        tb_stall1 = 1'b1; req_valid = 1'b1; req_pc = 64'h8000_2000;
        for (int k = 0; k < 4; k++) begin
            tick();
            req_pc = req_pc + 64'd4;
        end
        tb_stall1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            pre = (dut.count_q == 3'd3) && dut.p_valid_q && (dut.wr_ptr_q == 2'd3);
            if (pre) begin
                vectors++;
                if (stallreq_fq !== 1'b1) begin
                    miscompares++; $display("FAIL wrap_stallreq got %b expected 1", stallreq_fq);
                end
            end
            acc = req_valid && !stall[0];
            tick();
            if (acc) req_pc = req_pc + 64'd4;
            if (pre) begin
                hits++;
                vectors++;
                if (dut.count_q !== 3'd3 || dut.wr_ptr_q !== 2'd0) begin
                    miscompares++;
                    $display("FAIL wrap_simul got count=%0d wr=%0d expected 3/0", dut.count_q, dut.wr_ptr_q);
                end
            end
        end
        vectors++;
        if (hits !== 1) begin
            miscompares++; $display("FAIL wrap_hits got %0d expected 1", hits);
        end
        idle(8);
    endtask

    task automatic test_reset_mid();
        tb_stall1 = 1'b1; req_valid = 1'b1; req_pc = 64'h8000_3000;
        repeat (3) tick();
        rst = 1'b1; br_e = 1'b1;
        tick();
        rst = 1'b0; br_e = 1'b0; req_valid = 1'b0;
        vectors++;
        if (dut.count_q !== 3'd0 || bus !== 97'd0 || stallreq_fq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got count=%0d bus=%h full=%b expected 0", dut.count_q, bus, stallreq_fq);
        end
        idle(3);
    endtask

    initial begin
        rst = 1'b1; tb_stall0 = 1'b0; tb_stall1 = 1'b0; br_e = 1'b0; br_addr = 64'd0;
        req_valid = 1'b1; req_pc = 64'h1000; rdata = 64'd0; rand_rd = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        idle(4);
        test_if_stall();
        idle(4);
        test_flush();
        idle(4);
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound the whole run so the bench cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout reached at t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
